chan_select_mux: RTL and testbench
==================================

// Module: chan_select_mux
//
// PURPOSE
// - Parametrised N-channel, WIDTH-bit multiplexer with one registered output stage.
// - Successor to the 2:1 bit-wide select mux.
// - Adds a per-channel valid/ready handshake, output back-pressure, and two modes:
//   fixed select, or round-robin among the channels that are requesting.
// - Sits between several producer streams and a single consumer stream in the datapath.
//
// PARAMETERS
// - WIDTH     8                  data bits per channel (>=1)
// - CHANNELS  4                  number of input channels (>=2)
// - SELW      $clog2(CHANNELS)   width of select and y_chan; derived, do not override
//
// PORTS
// - clk      input   1               single clock; all state updates on the rising edge
// - rst_n    input   1               asynchronous, active-low reset
// - in_data  input   CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
// - in_valid input   CHANNELS        channel i is offering a word
// - in_ready output  CHANNELS        channel i's word is taken this cycle
// - mode     input   1               0 = fixed select, 1 = round-robin
// - select   input   SELW            channel index used when mode = 0
// - y        output  WIDTH           registered output data
// - y_valid  output  1               y holds a valid word
// - y_ready  input   1               consumer accepts y this cycle
// - y_chan   output  SELW            index of the channel that supplied y
//
// BEHAVIOUR
// - Reset (rst_n low, acts immediately, no clock needed):
//   - y = 0, y_valid = 0, y_chan = 0, round-robin pointer rr_ptr = 0.
//   - Any held word is dropped.
//   - in_ready is all-zero while in reset.
// - Load condition: load = !y_valid || y_ready. The output register can accept a word this cycle.
// - Grant (combinational, one-hot or none):
//   - mode = 0:
//     - The granted channel is select, whether or not that channel is valid.
//     - If select >= CHANNELS, nothing is granted.
//   - mode = 1:
//     - The granted channel is the first i with in_valid[i]=1, searching from rr_ptr upward.
//     - The search wraps from CHANNELS-1 to 0.
//     - If no channel is valid, nothing is granted.
// - in_ready[g] = load for the granted channel g; every other bit of in_ready is 0.
// - Transfer: a transfer happens when in_valid[g] && in_ready[g]. At the next edge:
//   - y <= in_data[g]
//   - y_chan <= g
//   - y_valid <= 1
// - Latency: exactly 1 cycle from input transfer to y_valid.
// - Throughput: 1 word per cycle while y_ready stays high.
// - Consume only: if y_valid && y_ready and no transfer happens, then y_valid <= 0.
//   - y and y_chan keep their last values.
// - Consume and transfer in the same cycle: the new word replaces the old one.
//   - y_valid stays 1. There is no bubble between words.
// - Back-pressure: while y_valid && !y_ready:
//   - y, y_chan and y_valid are held stable.
//   - in_ready is all-zero.
// - Round-robin pointer: on a transfer in mode = 1, rr_ptr <= (g == CHANNELS-1) ? 0 : g+1.
//   - rr_ptr is not updated in mode = 0. It keeps its value across mode changes.
// - Mode or select changes are sampled every cycle and apply to the very next grant.
//   - A word already held in y is not affected.
// - The block never creates a word. y_valid rises only after an input transfer.
// - A channel that stays valid under round-robin is granted at least once every CHANNELS transfers.
//
// TESTING
// - Reset check: assert rst_n=0 mid-stream while y_valid=1.
//   - Required: y=0, y_valid=0, y_chan=0 with no clock edge; in_ready=0000.
// - Fixed mode, CHANNELS=4, WIDTH=8, y_ready=1, mode=0, select=2, in_data ch2=8'hA5, all valid.
//   - Required: in_ready=0100; one cycle later y=A5, y_chan=2, y_valid=1.
// - Back-pressure: y_valid=1, y_ready=0 for 3 cycles, ch1 valid.
//   - Required: y and y_chan stable and in_ready=0000 for all 3 cycles.
//   - Then raise y_ready: ch1 is transferred on that same cycle, with y_valid held at 1.
// - Round-robin wrap: mode=1, rr_ptr=3, in_valid=1011, y_ready=1.
//   - Required: grants occur in the order 3, 0, 1, 3, 0.
//   - rr_ptr is 0 after the grant to 3.
// - Fairness/idle: mode=1, all 4 channels valid for 8 cycles.
//   - Required: each y_chan value appears exactly twice, in the order 0,1,2,3,0,1,2,3.
//   - Then drop all in_valid: y_valid falls 1 cycle after the last transfer is consumed.
// - Out-of-range select: CHANNELS=3, mode=0, select=3.
//   - Required: in_ready=000 and y_valid stays 0 while the consumer drains.

Source files
------------

// File: rtl/chan_select_mux.sv
// N-channel WIDTH-bit stream multiplexer with a valid/ready handshake on each side and a
// single registered output stage; the source is either a fixed select or round-robin over requesters.
module chan_select_mux #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           select,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [SELW-1:0]           y_chan
);

    logic [WIDTH-1:0]    y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic [SELW-1:0]     y_chan_q, y_chan_d;
    logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;

    logic                load_s;
    logic                grant_vld_s;
    logic [SELW-1:0]     grant_idx_s;
    logic [SELW-1:0]     cand_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic                transfer_s;

    // Channel index reached by stepping offs places upward from base, wrapping at CHANNELS.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int offs);
        int t;
        t = int'(base) + offs;
        return (t >= CHANNELS) ? SELW'(t - CHANNELS) : SELW'(t);
    endfunction

    // Grant selection: fixed select (range-checked) or first requester at or above rr_ptr.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        if (mode == 1'b0) begin
            if (int'(select) < CHANNELS) begin
                grant_vld_s = 1'b1;
                grant_idx_s = select;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cand_s = wrap_add(rr_ptr_q, k);
                if (!grant_vld_s && in_valid[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // Handshake: only the granted channel sees ready, and only when the output slot can load.
    always_comb begin
        load_s     = rst_n && (!y_valid_q || y_ready);
        in_ready_s = '0;
        sel_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_vld_s && (grant_idx_s == SELW'(k))) begin
                in_ready_s[k] = load_s;
                sel_data_s    = in_data[k*WIDTH +: WIDTH];
            end else begin
                in_ready_s[k] = 1'b0;
            end
        end
        transfer_s = |(in_ready_s & in_valid);
    end

    // Next state: a transfer overwrites the slot (even when it is consumed the same cycle).
    always_comb begin
        y_d       = y_q;
        y_chan_d  = y_chan_q;
        y_valid_d = y_valid_q;
        rr_ptr_d  = rr_ptr_q;
        if (transfer_s) begin
            y_d       = sel_data_s;
            y_chan_d  = grant_idx_s;
            y_valid_d = 1'b1;
            if (mode == 1'b1) begin
                rr_ptr_d = (grant_idx_s == SELW'(CHANNELS - 1)) ? '0 : grant_idx_s + SELW'(1);
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end else begin
            y_valid_d = y_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_chan_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_chan_q  <= y_chan_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign in_ready = in_ready_s;
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign y_chan   = y_chan_q;

endmodule

// File: tb/tb_chan_select_mux.sv
// Directed bench for chan_select_mux: a 4-channel instance for the main flow and a
// 3-channel instance for the out-of-range select case.
module tb_chan_select_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic        a_mode, a_y_valid, a_y_ready;
    logic [1:0]  a_select, a_y_chan;
    logic [7:0]  a_y;

    // 3-channel instance
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic        b_mode, b_y_valid, b_y_ready;
    logic [1:0]  b_select, b_y_chan;
    logic [7:0]  b_y;

    int checks = 0;
    int errors = 0;

    chan_select_mux #(.WIDTH(8), .CHANNELS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .mode(a_mode), .select(a_select), .y(a_y),
        .y_valid(a_y_valid), .y_ready(a_y_ready), .y_chan(a_y_chan)
    );

    chan_select_mux #(.WIDTH(8), .CHANNELS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mode(b_mode), .select(b_select), .y(b_y),
        .y_valid(b_y_valid), .y_ready(b_y_ready), .y_chan(b_y_chan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] dat [4];
    int         rr_exp [5];
    logic [3:0] oh;

    initial begin
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h33;
        rr_exp[0] = 3; rr_exp[1] = 0; rr_exp[2] = 1; rr_exp[3] = 3; rr_exp[4] = 0;

        rst_n      = 1'b0;
        a_in_data  = {dat[3], dat[2], dat[1], dat[0]};
        a_in_valid = 4'b1111;
        a_mode     = 1'b0;
        a_select   = 2'd2;
        a_y_ready  = 1'b1;
        b_in_data  = {8'h77, 8'h66, 8'h55};
        b_in_valid = 3'b000;
        b_mode     = 1'b0;
        b_select   = 2'd0;
        b_y_ready  = 1'b1;

        // Reset state at power-up
        #1;
        chk("rst_y", a_y, 8'h00);
        chk("rst_y_valid", a_y_valid, 1'b0);
        chk("rst_y_chan", a_y_chan, 2'd0);
        chk("rst_in_ready", a_in_ready, 4'b0000);
        #6 rst_n = 1'b1;
        #1;

        // Fixed select of channel 2
        chk("fix_in_ready", a_in_ready, 4'b0100);
        tick();
        chk("fix_y", a_y, 8'hA5);
        chk("fix_y_chan", a_y_chan, 2'd2);
        chk("fix_y_valid", a_y_valid, 1'b1);

        // Back-pressure for 3 cycles with channel 1 offering
        a_y_ready  = 1'b0;
        a_select   = 2'd1;
        a_in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", a_in_ready, 4'b0000);
            chk("bp_y", a_y, 8'hA5);
            chk("bp_y_chan", a_y_chan, 2'd2);
            chk("bp_y_valid", a_y_valid, 1'b1);
            tick();
        end
        a_y_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", a_in_ready, 4'b0010);
        tick();
        chk("bp_release_y", a_y, 8'h22);
        chk("bp_release_y_chan", a_y_chan, 2'd1);
        chk("bp_release_y_valid", a_y_valid, 1'b1);

        // Move rr_ptr to 3 with a single round-robin grant to channel 2
        a_mode     = 1'b1;
        a_in_valid = 4'b0100;
        tick();
        chk("rr_prep_y_chan", a_y_chan, 2'd2);
        chk("rr_prep_ptr", dut_a.rr_ptr_q, 2'd3);

        // Round-robin wrap with channels 0,1,3 requesting
        a_in_valid = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            #1;
            oh = 4'b0001 << rr_exp[k];
            chk("rr_in_ready", a_in_ready, oh);
            tick();
            chk("rr_y_chan", a_y_chan, rr_exp[k]);
            chk("rr_y", a_y, dat[rr_exp[k]]);
            chk("rr_y_valid", a_y_valid, 1'b1);
            if (k == 0) chk("rr_ptr_after_3", dut_a.rr_ptr_q, 2'd0);
        end

        // Single grant to channel 3 returns rr_ptr to 0
        a_in_valid = 4'b1000;
        tick();
        chk("fair_prep_y_chan", a_y_chan, 2'd3);

        // Fairness: all channels requesting for 8 transfers
        a_in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fair_y_chan", a_y_chan, k % 4);
            chk("fair_y", a_y, dat[k % 4]);
        end
        a_in_valid = 4'b0000;
        #1;
        chk("idle_in_ready", a_in_ready, 4'b0000);
        chk("idle_y_valid_before", a_y_valid, 1'b1);
        tick();
        chk("idle_y_valid_after", a_y_valid, 1'b0);
        chk("idle_y_hold", a_y, 8'h33);
        chk("idle_y_chan_hold", a_y_chan, 2'd3);

        // Out-of-range select on the 3-channel instance
        b_in_valid = 3'b111;
        b_select   = 2'd0;
        tick();
        chk("oor_load_y", b_y, 8'h55);
        chk("oor_load_y_valid", b_y_valid, 1'b1);
        b_select = 2'd3;
        #1;
        chk("oor_in_ready", b_in_ready, 3'b000);
        tick();
        chk("oor_drain_y_valid", b_y_valid, 1'b0);
        chk("oor_in_ready2", b_in_ready, 3'b000);
        tick();
        chk("oor_stay_y_valid", b_y_valid, 1'b0);

        // Asynchronous reset while a word is held
        a_mode     = 1'b0;
        a_select   = 2'd2;
        a_in_valid = 4'b0100;
        tick();
        chk("mid_y_valid", a_y_valid, 1'b1);
        a_in_valid = 4'b0000;
        a_y_ready  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_y", a_y, 8'h00);
        chk("mid_rst_y_valid", a_y_valid, 1'b0);
        chk("mid_rst_y_chan", a_y_chan, 2'd0);
        a_in_valid = 4'b1111;
        #1;
        chk("mid_rst_in_ready", a_in_ready, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
